// File: rtl/imem_loader.sv
// Writable instruction memory with a big-endian byte-stream boot loader.
// The fetch stage reads the RAM combinationally via PC; cpu_hold stalls the core while a load runs.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   PC,
    output logic [31:0]   Inst,
    input  logic          load_start,
    input  logic [AW:0]   load_words,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          cpu_hold,
    output logic          load_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

    state_t        state;
    state_t        next_state;
    logic [31:0]   ram [DEPTH];
    logic [AW:0]   len;
    logic [AW:0]   len_req;
    logic [AW-1:0] addr;
    logic [1:0]    byte_cnt;
    logic [31:0]   asm_word;
    logic          xfer;
    logic          word_wr;
    logic          last_word;
    logic          unused_pc;

    assign Inst = ram[PC[AW+1:2]];
    // Byte-offset and high PC bits do not select a word.
    assign unused_pc = ^{PC[31:AW+2], PC[1:0]};

    assign len_req   = (load_words > DEPTH_LEN) ? DEPTH_LEN : load_words;
    assign xfer      = byte_valid && byte_ready;
    assign word_wr   = xfer && (byte_cnt == 2'd3);
    assign last_word = (({1'b0, addr} + (AW+1)'(1)) == len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len      <= '0;
            addr     <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= '0;
            end
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        len      <= len_req;
                        addr     <= '0;
                        byte_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        asm_word <= {asm_word[23:0], byte_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        // Fourth byte completes the word; write it on this same edge.
                        if (byte_cnt == 2'd3) begin
                            ram[addr] <= {asm_word[23:0], byte_data};
                            if (!last_word) begin
                                addr <= addr + AW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        cpu_hold   = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    next_state = (len_req == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                cpu_hold   = 1'b1;
                byte_ready = 1'b1;
                if (word_wr && last_word) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                cpu_hold   = 1'b1;
                load_done  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
